uart_regs: RTL and testbench
============================

// Module: uart_regs
// PURPOSE
// 16550-style byte-wide register file and sequencer sitting between the host bus and uart_top.
// Decodes host reads/writes into LCR/divisor/prescaler configuration, TX FIFO pushes and RX FIFO
// pops. Sticky line-status error bits and a prioritised interrupt (IIR/irq) are built from the
// uart_top status/pulse outputs. One per UART instance, same clock domain as uart_top.
// PARAMETERS
// DL_WIDTH   16  divisor_latch width; legal 9..16 (DLL = bits 7:0, DLM = bits DL_WIDTH-1:8)
// PSD_WIDTH  4   prescaler width; PSD register uses bits PSD_WIDTH-1:0
// PORTS
// clk           in   1         system clock, all logic on rising edge
// rst           in   1         synchronous, active-high reset
// cs            in   1         bus select; qualifies we/re
// we            in   1         write strobe (1-cycle)
// re            in   1         read strobe (1-cycle)
// addr          in   3         register offset
// wdata         in   8         write data
// rdata         out  8         read data, registered, valid cycle after re
// irq           out  1         interrupt request, level, = ~IIR[0]
// wr_en/wr_data out  1/8       TX FIFO push to uart_top
// tx_ready      in   1         TX FIFO not full
// rd_en         out  1         RX FIFO pop to uart_top
// rd_data       in   8         RX FIFO head (show-ahead, valid while rx_ready)
// rx_ready      in   1         RX FIFO not empty
// parity_err/framing_err/overrun_err in 1 each  1-cycle error pulses
// stop_bits     out  2         LCR[2] ? 2'd2 : 2'd1
// parity_en/parity_even out 1  LCR[3] / LCR[4]
// data_bits     out  4         5 + LCR[1:0]
// divisor_latch out  DL_WIDTH  {DLM,DLL};  psd out PSD_WIDTH;  new_baud out 1 (1-cycle pulse)
// BEHAVIOUR
// Map (DLAB=LCR[7]):
//   0 W: THR(D0)/DLL(D1)   R: RBR(D0)/DLL(D1)
//   1 RW: IER[3:0](D0)/DLM(D1)
//   2 R: IIR   W: ignored
//   3 RW: LCR
//   5 R: LSR   W: PSD when DLAB=1, else ignored
//   7 RW: SCR
//   4/6 read 0x00.
// Reset: LCR=0x03, DLL=0x01, DLM=0, PSD=0, IER=0, SCR=0, sticky bits=0, rdata=0;
//   wr_en=rd_en=0; irq=0.
// new_baud: registered 1-cycle pulse the cycle after any DLL/DLM/PSD write. Also pulses once in
//   the first cycle after rst deasserts. divisor_latch/psd update at the write edge, so they are
//   stable when new_baud is high.
// THR write: wr_en=1 and wr_data=wdata the cycle after the write if tx_ready was 1 at the write.
//   Otherwise the byte is dropped silently.
// RBR read: if rx_ready, rdata<=rd_data and rd_en pulses 1 cycle, aligned with rdata update.
//   If empty: rdata<=0x00 and no pop.
// LSR = {1'b0, TEMT=tx_ready, THRE=tx_ready, 1'b0, FE, PE, OE, DR=rx_ready}.
//   FE/PE/OE are sticky, set by their pulses and cleared by an LSR read.
//   A pulse in the same cycle as an LSR read: the read returns the old value and the bit stays set.
// IIR = {2'b11, 2'b00, code}, evaluated in priority order:
//   0110 line status (IER[2] & any sticky)
//   0100 RX data (IER[0] & rx_ready)
//   0010 THRE (IER[1] & thre_pend)
//   0001 none
// thre_pend: set on a tx_ready 0->1 edge, or on an IER write that sets bit1 while tx_ready=1.
//   Cleared by an IIR read returning 0010, or by a THR write.
//   If set and clear occur in the same cycle, set wins.
// irq is registered: it follows IIR one cycle later.
// we and re both asserted: the write is performed, the read is ignored and rdata holds.
// cs=0: strobes ignored. rst mid-transfer: all state returns to reset values next edge;
//   pending wr_en/rd_en are suppressed.
// STRUCTURE
// Package uart_pkg: address localparams, LCR bit indices, IIR code constants, LSR bit indices.
// Sub-module uart_irq_prio: sticky LSR bits, thre_pend, IIR encode, irq register.
// uart_regs holds the decode, the config registers and the bus read mux.
// TESTING
// 1. Reset release -> new_baud pulses once; data_bits=8, stop_bits=1, parity_en=0,
//    divisor_latch=0x0001.
// 2. Write LCR=0x80, addr0=0x34, addr1=0x12, addr5=0x5, LCR=0x1B
//    -> divisor_latch=0x1234, psd=5, new_baud pulses 3x, data_bits=8, parity even.
// 3. tx_ready=1, write THR=0xA5 -> wr_en one cycle with wr_data=0xA5.
//    Same write with tx_ready=0 -> no wr_en.
// 4. rx_ready=1, rd_data=0x5A, read RBR -> rdata=0x5A and rd_en single pulse.
//    rx_ready=0 -> rdata=0x00, no pop.
// 5. Pulse framing_err, read LSR -> bit3=1; second LSR read -> bit3=0.
//    A pulse coinciding with the read survives to the next read.
// 6. IER=0x07, with OE set, rx_ready=1 and THRE pending -> IIR=0xC6.
//    Clear LSR -> 0xC4. Drain RX -> 0xC2. Read IIR -> next read 0xC1, irq low.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the 16550-style UART register file: register offsets,
// LCR/LSR bit positions and IIR interrupt codes.
package uart_pkg;

   localparam logic [2:0] ADDR_RBR_THR = 3'd0;
   localparam logic [2:0] ADDR_IER     = 3'd1;
   localparam logic [2:0] ADDR_IIR     = 3'd2;
   localparam logic [2:0] ADDR_LCR     = 3'd3;
   localparam logic [2:0] ADDR_LSR     = 3'd5;
   localparam logic [2:0] ADDR_SCR     = 3'd7;

   localparam int LCR_STB  = 2;
   localparam int LCR_PEN  = 3;
   localparam int LCR_EPS  = 4;
   localparam int LCR_DLAB = 7;

   localparam int LSR_DR   = 0;
   localparam int LSR_OE   = 1;
   localparam int LSR_PE   = 2;
   localparam int LSR_FE   = 3;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;

   localparam logic [3:0] IIR_LS   = 4'b0110;
   localparam logic [3:0] IIR_RX   = 4'b0100;
   localparam logic [3:0] IIR_THRE = 4'b0010;
   localparam logic [3:0] IIR_NONE = 4'b0001;

endpackage

// File: rtl/uart_irq_prio.sv
// Sticky line-status bits, THRE-pending flag, prioritised IIR encode and the
// registered interrupt request.
module uart_irq_prio
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] ier,
   input  logic       tx_ready,
   input  logic       rx_ready,
   input  logic       parity_err,
   input  logic       framing_err,
   input  logic       overrun_err,
   input  logic       lsr_rd,
   input  logic       iir_rd,
   input  logic       thr_wr,
   input  logic       ier_wr,
   input  logic       ier_thre_bit,
   output logic [7:0] lsr,
   output logic [7:0] iir,
   output logic       irq
);

   logic pe_q, pe_d, fe_q, fe_d, oe_q, oe_d;
   logic thre_q, thre_d, thre_set, thre_clr;
   logic tx_ready_q;
   logic irq_q, irq_d;
   logic [3:0] code;

   always_comb begin
      // A pulse landing on the LSR read cycle re-sets the bit for the next read.
      pe_d = parity_err  | (pe_q & ~lsr_rd);
      fe_d = framing_err | (fe_q & ~lsr_rd);
      oe_d = overrun_err | (oe_q & ~lsr_rd);

      if (ier[2] & (pe_q | fe_q | oe_q)) code = IIR_LS;
      else if (ier[0] & rx_ready)        code = IIR_RX;
      else if (ier[1] & thre_q)          code = IIR_THRE;
      else                               code = IIR_NONE;

      thre_set = (tx_ready & ~tx_ready_q) | (ier_wr & ier_thre_bit & tx_ready);
      thre_clr = (iir_rd & (code == IIR_THRE)) | thr_wr;
      thre_d   = thre_set | (thre_q & ~thre_clr);

      irq_d = ~code[0];

      lsr           = 8'h00;
      lsr[LSR_DR]   = rx_ready;
      lsr[LSR_OE]   = oe_q;
      lsr[LSR_PE]   = pe_q;
      lsr[LSR_FE]   = fe_q;
      lsr[LSR_THRE] = tx_ready;
      lsr[LSR_TEMT] = tx_ready;
   end

   assign iir = {2'b11, 2'b00, code};
   assign irq = irq_q;

   always_ff @(posedge clk) begin
      // tx_ready is tracked through reset so leaving reset with it high is not an edge.
      tx_ready_q <= tx_ready;
      if (rst) begin
         pe_q   <= 1'b0;
         fe_q   <= 1'b0;
         oe_q   <= 1'b0;
         thre_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         pe_q   <= pe_d;
         fe_q   <= fe_d;
         oe_q   <= oe_d;
         thre_q <= thre_d;
         irq_q  <= irq_d;
      end
   end

endmodule

// File: rtl/uart_regs.sv
// Host-bus register file for one UART: address decode, line/baud configuration,
// TX push / RX pop sequencing and the registered read-data mux.
module uart_regs
   import uart_pkg::*;
#(
   parameter int DL_WIDTH  = 16,
   parameter int PSD_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cs,
   input  logic                 we,
   input  logic                 re,
   input  logic [2:0]           addr,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata,
   output logic                 irq,
   output logic                 wr_en,
   output logic [7:0]           wr_data,
   input  logic                 tx_ready,
   output logic                 rd_en,
   input  logic [7:0]           rd_data,
   input  logic                 rx_ready,
   input  logic                 parity_err,
   input  logic                 framing_err,
   input  logic                 overrun_err,
   output logic [1:0]           stop_bits,
   output logic                 parity_en,
   output logic                 parity_even,
   output logic [3:0]           data_bits,
   output logic [DL_WIDTH-1:0]  divisor_latch,
   output logic [PSD_WIDTH-1:0] psd,
   output logic                 new_baud
);

   logic [7:0]           lcr_q, lcr_d, dll_q, dll_d, scr_q, scr_d;
   logic [7:0]           rdata_q, rdata_d, wr_data_q, wr_data_d;
   logic [DL_WIDTH-9:0]  dlm_q, dlm_d;
   logic [PSD_WIDTH-1:0] psd_q, psd_d;
   logic [3:0]           ier_q, ier_d;
   logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic                 new_baud_q, new_baud_d, first_q, first_d;
   logic                 wr_acc, rd_acc, dlab;
   logic                 lsr_rd, iir_rd, thr_wr, ier_wr;
   logic [7:0]           lsr, iir;

   assign wr_acc = cs & we;
   assign rd_acc = cs & re & ~we;
   assign dlab   = lcr_q[LCR_DLAB];

   always_comb begin
      lcr_d      = lcr_q;
      dll_d      = dll_q;
      dlm_d      = dlm_q;
      psd_d      = psd_q;
      ier_d      = ier_q;
      scr_d      = scr_q;
      rdata_d    = rdata_q;
      wr_data_d  = wr_data_q;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      // first_q turns the first post-reset cycle into a baud reload.
      new_baud_d = first_q;
      first_d    = 1'b0;
      lsr_rd     = 1'b0;
      iir_rd     = 1'b0;
      thr_wr     = 1'b0;
      ier_wr     = 1'b0;

      if (wr_acc) begin
         case (addr)
            ADDR_RBR_THR: begin
               if (dlab) begin
                  dll_d      = wdata;
                  new_baud_d = 1'b1;
               end else begin
                  thr_wr = 1'b1;
                  if (tx_ready) begin
                     wr_en_d   = 1'b1;
                     wr_data_d = wdata;
                  end
               end
            end
            ADDR_IER: begin
               if (dlab) begin
                  dlm_d      = wdata[DL_WIDTH-9:0];
                  new_baud_d = 1'b1;
               end else begin
                  ier_d  = wdata[3:0];
                  ier_wr = 1'b1;
               end
            end
            ADDR_LCR: lcr_d = wdata;
            ADDR_LSR: begin
               if (dlab) begin
                  psd_d      = wdata[PSD_WIDTH-1:0];
                  new_baud_d = 1'b1;
               end
            end
            ADDR_SCR: scr_d = wdata;
            default: ;
         endcase
      end else if (rd_acc) begin
         case (addr)
            ADDR_RBR_THR: begin
               if (dlab) begin
                  rdata_d = dll_q;
               end else if (rx_ready) begin
                  rdata_d = rd_data;
                  rd_en_d = 1'b1;
               end else begin
                  rdata_d = 8'h00;
               end
            end
            ADDR_IER: rdata_d = dlab ? 8'(dlm_q) : {4'b0000, ier_q};
            ADDR_IIR: begin
               rdata_d = iir;
               iir_rd  = 1'b1;
            end
            ADDR_LCR: rdata_d = lcr_q;
            ADDR_LSR: begin
               rdata_d = lsr;
               lsr_rd  = 1'b1;
            end
            ADDR_SCR: rdata_d = scr_q;
            default:  rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lcr_q      <= 8'h03;
         dll_q      <= 8'h01;
         dlm_q      <= '0;
         psd_q      <= '0;
         ier_q      <= 4'h0;
         scr_q      <= 8'h00;
         rdata_q    <= 8'h00;
         wr_data_q  <= 8'h00;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         new_baud_q <= 1'b0;
         first_q    <= 1'b1;
      end else begin
         lcr_q      <= lcr_d;
         dll_q      <= dll_d;
         dlm_q      <= dlm_d;
         psd_q      <= psd_d;
         ier_q      <= ier_d;
         scr_q      <= scr_d;
         rdata_q    <= rdata_d;
         wr_data_q  <= wr_data_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         new_baud_q <= new_baud_d;
         first_q    <= first_d;
      end
   end

   uart_irq_prio u_irq_prio (
      .clk          (clk),
      .rst          (rst),
      .ier          (ier_q[2:0]),
      .tx_ready     (tx_ready),
      .rx_ready     (rx_ready),
      .parity_err   (parity_err),
      .framing_err  (framing_err),
      .overrun_err  (overrun_err),
      .lsr_rd       (lsr_rd),
      .iir_rd       (iir_rd),
      .thr_wr       (thr_wr),
      .ier_wr       (ier_wr),
      .ier_thre_bit (wdata[1]),
      .lsr          (lsr),
      .iir          (iir),
      .irq          (irq)
   );

   assign rdata         = rdata_q;
   assign wr_en         = wr_en_q;
   assign wr_data       = wr_data_q;
   assign rd_en         = rd_en_q;
   assign new_baud      = new_baud_q;
   assign stop_bits     = lcr_q[LCR_STB] ? 2'd2 : 2'd1;
   assign parity_en     = lcr_q[LCR_PEN];
   assign parity_even   = lcr_q[LCR_EPS];
   assign data_bits     = 4'd5 + {2'b00, lcr_q[1:0]};
   assign divisor_latch = {dlm_q, dll_q};
   assign psd           = psd_q;

endmodule

// File: tb/tb_uart_regs.sv
// Scoreboard bench for uart_regs: bus reads and TX pushes queue their expected
// results, a monitor pops and compares whenever the DUT produces them.
module tb_uart_regs;

   logic        clk = 1'b0;
   logic        rst, cs, we, re, tx_ready, rx_ready;
   logic        parity_err, framing_err, overrun_err;
   logic [2:0]  addr;
   logic [7:0]  wdata, rd_data;
   logic [7:0]  rdata, wr_data;
   logic        irq, wr_en, rd_en, parity_en, parity_even, new_baud;
   logic [1:0]  stop_bits;
   logic [3:0]  data_bits;
   logic [15:0] divisor_latch;
   logic [3:0]  psd;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
   } rd_exp_t;

   rd_exp_t    rd_q[$];
   logic [7:0] wr_q[$];
   int         tests  = 0;
   int         failed = 0;
   int         nb_cnt = 0;

   always #5 clk = ~clk;

   uart_regs dut (
      .clk           (clk),
      .rst           (rst),
      .cs            (cs),
      .we            (we),
      .re            (re),
      .addr          (addr),
      .wdata         (wdata),
      .rdata         (rdata),
      .irq           (irq),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .tx_ready      (tx_ready),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rx_ready      (rx_ready),
      .parity_err    (parity_err),
      .framing_err   (framing_err),
      .overrun_err   (overrun_err),
      .stop_bits     (stop_bits),
      .parity_en     (parity_en),
      .parity_even   (parity_even),
      .data_bits     (data_bits),
      .divisor_latch (divisor_latch),
      .psd           (psd),
      .new_baud      (new_baud)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] e, input logic p);
      rd_exp_t x;
      x.d = e;
      x.p = p;
      rd_q.push_back(x);
      cs = 1'b1; re = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0; re = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: samples just after each rising edge.
   initial begin
      bit      issued;
      rd_exp_t x;
      logic [7:0] e;
      forever begin
         @(posedge clk);
         issued = cs && re && !we && !rst;
         #2;
         if (new_baud) nb_cnt++;
         if (wr_en) begin
            if (wr_q.size() == 0) begin
               tests++; failed++;
               $display("FAIL wr_en_unexpected: got wr_en=1 wr_data=0x%0h, expected wr_en=0", wr_data);
            end else begin
               e = wr_q.pop_front();
               chk("wr_data", {8'h00, wr_data}, {8'h00, e});
            end
         end
         if (issued) begin
            if (rd_q.size() == 0) begin
               tests++; failed++;
               $display("FAIL rd_unexpected: got rdata=0x%0h, expected no read", rdata);
            end else begin
               x = rd_q.pop_front();
               chk("rdata", {8'h00, rdata}, {8'h00, x.d});
               chk("rd_en", {15'd0, rd_en}, {15'd0, x.p});
            end
         end else if (rd_en) begin
            tests++; failed++;
            $display("FAIL rd_en_unexpected: got rd_en=1, expected 0");
         end
      end
   end

   initial begin
      rst = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0; addr = 3'd0; wdata = 8'h00;
      tx_ready = 1'b0; rx_ready = 1'b0; rd_data = 8'h00;
      parity_err = 1'b0; framing_err = 1'b0; overrun_err = 1'b0;
      idle(3);
      chk("reset_new_baud", {15'd0, new_baud}, 16'd0);
      chk("reset_rdata", {8'h00, rdata}, 16'h0000);
      chk("reset_irq", {15'd0, irq}, 16'd0);
      rst = 1'b0;
      idle(3);

      // Reset release and defaults
      chk("nb_after_reset", nb_cnt[15:0], 16'd1);
      chk("data_bits_rst", {12'd0, data_bits}, 16'd8);
      chk("stop_bits_rst", {14'd0, stop_bits}, 16'd1);
      chk("parity_en_rst", {15'd0, parity_en}, 16'd0);
      chk("divisor_rst", divisor_latch, 16'h0001);
      chk("psd_rst", {12'd0, psd}, 16'd0);
      rd(3'd3, 8'h03, 1'b0);
      rd(3'd4, 8'h00, 1'b0);

      // Baud and line configuration
      wr(3'd3, 8'h80);
      wr(3'd0, 8'h34);
      wr(3'd1, 8'h12);
      wr(3'd5, 8'h05);
      rd(3'd0, 8'h34, 1'b0);
      rd(3'd1, 8'h12, 1'b0);
      wr(3'd3, 8'h1B);
      idle(2);
      chk("divisor_cfg", divisor_latch, 16'h1234);
      chk("psd_cfg", {12'd0, psd}, 16'd5);
      chk("nb_after_cfg", nb_cnt[15:0], 16'd4);
      chk("data_bits_cfg", {12'd0, data_bits}, 16'd8);
      chk("stop_bits_cfg", {14'd0, stop_bits}, 16'd1);
      chk("parity_en_cfg", {15'd0, parity_en}, 16'd1);
      chk("parity_even_cfg", {15'd0, parity_even}, 16'd1);
      rd(3'd3, 8'h1B, 1'b0);
      wr(3'd7, 8'h5A);
      rd(3'd7, 8'h5A, 1'b0);

      // TX pushes
      tx_ready = 1'b1;
      idle(1);
      wr_q.push_back(8'hA5);
      wr(3'd0, 8'hA5);
      tx_ready = 1'b0;
      wr(3'd0, 8'h11);
      idle(2);

      // RX pops, simultaneous strobes, deselected strobes
      rx_ready = 1'b1; rd_data = 8'h5A;
      rd(3'd0, 8'h5A, 1'b1);
      rx_ready = 1'b0;
      rd(3'd0, 8'h00, 1'b0);
      cs = 1'b1; we = 1'b1; re = 1'b1; addr = 3'd7; wdata = 8'h77;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; re = 1'b0;
      chk("we_re_rdata_hold", {8'h00, rdata}, 16'h0000);
      we = 1'b1; addr = 3'd7; wdata = 8'hEE;
      @(negedge clk);
      we = 1'b0;
      rd(3'd7, 8'h77, 1'b0);

      // Sticky framing error
      framing_err = 1'b1; idle(1); framing_err = 1'b0;
      rd(3'd5, 8'h08, 1'b0);
      rd(3'd5, 8'h00, 1'b0);
      framing_err = 1'b1;
      rd(3'd5, 8'h00, 1'b0);
      framing_err = 1'b0;
      rd(3'd5, 8'h08, 1'b0);
      rd(3'd5, 8'h00, 1'b0);

      // Interrupt priority
      wr(3'd1, 8'h07);
      overrun_err = 1'b1; idle(1); overrun_err = 1'b0;
      tx_ready = 1'b1; rx_ready = 1'b1; rd_data = 8'h33;
      idle(2);
      chk("irq_pending", {15'd0, irq}, 16'd1);
      rd(3'd2, 8'hC6, 1'b0);
      rd(3'd5, 8'h63, 1'b0);
      rd(3'd2, 8'hC4, 1'b0);
      rd(3'd0, 8'h33, 1'b1);
      rx_ready = 1'b0;
      rd(3'd2, 8'hC2, 1'b0);
      rd(3'd2, 8'hC1, 1'b0);
      chk("irq_cleared", {15'd0, irq}, 16'd0);

      // THRE set by IER write, cleared by THR write; set wins over clear
      wr(3'd1, 8'h00);
      wr(3'd1, 8'h02);
      rd(3'd2, 8'hC2, 1'b0);
      rd(3'd2, 8'hC1, 1'b0);
      wr(3'd1, 8'h02);
      wr_q.push_back(8'h99);
      wr(3'd0, 8'h99);
      rd(3'd2, 8'hC1, 1'b0);
      tx_ready = 1'b0;
      idle(1);
      tx_ready = 1'b1;
      wr_q.push_back(8'h66);
      wr(3'd0, 8'h66);
      rd(3'd2, 8'hC2, 1'b0);
      rd(3'd2, 8'hC1, 1'b0);

      // Reset while a THR write is on the bus
      rst = 1'b1; cs = 1'b1; we = 1'b1; addr = 3'd0; wdata = 8'h44;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
      idle(1);
      rst = 1'b0;
      idle(3);
      chk("nb_after_rst2", nb_cnt[15:0], 16'd5);
      chk("divisor_rst2", divisor_latch, 16'h0001);
      chk("irq_rst2", {15'd0, irq}, 16'd0);
      rd(3'd3, 8'h03, 1'b0);
      rd(3'd1, 8'h00, 1'b0);
      idle(3);

      chk("rd_queue_empty", rd_q.size(), 16'd0);
      chk("wr_queue_empty", wr_q.size(), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
